// File: rtl/icache_dm.sv
// icache_dm: direct-mapped, one-word-per-line instruction cache with single-word miss refill
// and flush handling that drains an already-started memory transfer.
module icache_dm #(
    parameter int INDEX_BITS = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        flush,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_addr,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic        busy,
    output logic        valid_to_mem,
    output logic [31:0] addr_to_mem,
    input  logic        valid_from_mem,
    input  logic [31:0] data_from_mem
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_BITS = 30 - INDEX_BITS;

    typedef enum logic [1:0] {IDLE, MISS, DRAIN} state_t;

    state_t                state_q, state_d;
    logic                  inst_valid_q, inst_valid_d;
    logic [31:0]           inst_q, inst_d;
    logic [31:0]           addr_q, addr_d;
    logic                  valid_to_mem_q, valid_to_mem_d;
    logic                  fill_en;
    logic                  hit;
    logic                  line_valid_q [LINES];
    logic [TAG_BITS-1:0]   line_tag_q [LINES];
    logic [31:0]           line_data_q [LINES];
    logic [INDEX_BITS-1:0] req_idx, fill_idx;
    logic [TAG_BITS-1:0]   req_tag, fill_tag;

    assign req_idx  = fetch_addr[INDEX_BITS+1:2];
    assign req_tag  = fetch_addr[31:INDEX_BITS+2];
    assign fill_idx = addr_q[INDEX_BITS+1:2];
    assign fill_tag = addr_q[31:INDEX_BITS+2];
    assign hit      = line_valid_q[req_idx] && (line_tag_q[req_idx] == req_tag);

    always_comb begin
        state_d        = state_q;
        inst_valid_d   = 1'b0;
        inst_d         = inst_q;
        addr_d         = addr_q;
        valid_to_mem_d = valid_to_mem_q;
        fill_en        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fetch_valid && !flush) begin
                    if (hit) begin
                        inst_d       = line_data_q[req_idx];
                        inst_valid_d = 1'b1;
                    end else begin
                        addr_d         = fetch_addr & ~32'h3;
                        valid_to_mem_d = 1'b1;
                        state_d        = MISS;
                    end
                end
            end
            MISS: begin
                if (valid_from_mem) begin
                    fill_en        = 1'b1;
                    valid_to_mem_d = 1'b0;
                    state_d        = IDLE;
                    inst_d         = flush ? inst_q : data_from_mem;
                    inst_valid_d   = !flush;
                end else if (flush) begin
                    // The memory controller cannot abort, so keep the request up until it completes.
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (valid_from_mem) begin
                    fill_en        = 1'b1;
                    valid_to_mem_d = 1'b0;
                    state_d        = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            inst_valid_q   <= 1'b0;
            inst_q         <= '0;
            addr_q         <= '0;
            valid_to_mem_q <= 1'b0;
            for (int i = 0; i < LINES; i++) line_valid_q[i] <= 1'b0;
        end else if (rdy) begin
            state_q        <= state_d;
            inst_valid_q   <= inst_valid_d;
            inst_q         <= inst_d;
            addr_q         <= addr_d;
            valid_to_mem_q <= valid_to_mem_d;
            if (fill_en) line_valid_q[fill_idx] <= 1'b1;
        end
    end

    // Tag and data need no reset: they are only read behind a set valid bit.
    always_ff @(posedge clk) begin
        if (!rst && rdy && fill_en) begin
            line_tag_q[fill_idx]  <= fill_tag;
            line_data_q[fill_idx] <= data_from_mem;
        end
    end

    assign inst_valid   = inst_valid_q;
    assign inst         = inst_q;
    assign busy         = state_q != IDLE;
    assign valid_to_mem = valid_to_mem_q;
    assign addr_to_mem  = addr_q;
endmodule
